// File: rtl/lbus_pkg.sv
// lbus_pkg: shared command codes, FSM encoding, register map and byte-order helper for the local bus
package lbus_pkg;
  localparam logic [7:0] LBUS_CMD_RD = 8'h00;
  localparam logic [7:0] LBUS_CMD_WR = 8'h01;
  localparam logic [15:0] LBUS_ADDR_CTRL = 16'h0002;
  localparam logic [15:0] LBUS_ADDR_MODE = 16'h000c;
  localparam logic [15:0] LBUS_ADDR_KEY = 16'h0100;
  localparam logic [15:0] LBUS_ADDR_DIN = 16'h0140;
  localparam logic [15:0] LBUS_ADDR_DOUT = 16'h0180;
  localparam logic [15:0] LBUS_ADDR_ID = 16'hfffc;
  typedef enum logic [2:0] {IDLE, SEND, GAP, RD_WAIT, RD_HI, RD_GAP, RD_LO, DONE} lbus_state_t;
  function automatic logic [7:0] lbus_byte(input logic wr, input logic [15:0] addr, input logic [15:0] wdata, input logic [2:0] idx);
    return idx == 3'd0 ? (wr ? LBUS_CMD_WR : LBUS_CMD_RD) :
           idx == 3'd1 ? addr[15:8] :
           idx == 3'd2 ? addr[7:0] :
           idx == 3'd3 ? wdata[15:8] : wdata[7:0];
  endfunction
endpackage

// File: rtl/lbus_timeout_cnt.sv
// lbus_timeout_cnt: counts consecutive stall cycles and flags the cycle that reaches TIMEOUT
module lbus_timeout_cnt #(
  parameter int TIMEOUT = 1023,
  parameter int TO_W = 10
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TO_W-1:0] cnt;
  assign expired = en && cnt == TO_W'(TIMEOUT - 1);
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/lbus_master.sv
// lbus_master: byte-serial local bus initiator turning 16-bit register requests into HWE/HRE byte sequences
module lbus_master
  import lbus_pkg::*;
#(
  parameter int BYTE_GAP = 1,
  parameter int TIMEOUT = 1023,
  parameter int TO_W = 10
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [15:0] REQ_ADDR,
  input  logic [15:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [15:0] RSP_RDATA,
  output logic        RSP_ERR,
  input  logic        DEVRDY,
  input  logic        RRDYn,
  input  logic        WRDYn,
  output logic        HWE,
  output logic        HRE,
  output logic [7:0]  HDOUT,
  input  logic [7:0]  HDIN
);
  lbus_state_t state;
  logic [2:0] idx;
  logic [3:0] gap_cnt;
  logic wr_q;
  logic [15:0] addr_q, wdata_q;
  logic [7:0] rd_hi;
  logic to_en, to_exp, last, adv;
  assign REQ_READY = (state == IDLE) & DEVRDY;
  assign last = idx == (wr_q ? 3'd4 : 3'd2);
  assign adv = ~WRDYn & ((state == SEND && BYTE_GAP == 0) ||
                         (state == GAP && {1'b0, gap_cnt} + 5'd1 >= 5'(BYTE_GAP)));
  // the timeout measures an unbroken stall, so any ready cycle restarts it
  assign to_en = (state == GAP && WRDYn) || ((state == RD_WAIT || (state == RD_LO && !HRE)) && RRDYn);
  lbus_timeout_cnt #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_to (
    .CLK(CLK), .RSTn(RSTn), .clr(~to_en), .en(to_en), .expired(to_exp)
  );
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      state <= IDLE;
      idx <= '0;
      gap_cnt <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_hi <= '0;
      HWE <= 1'b0;
      HRE <= 1'b0;
      HDOUT <= '0;
      RSP_VALID <= 1'b0;
      RSP_ERR <= 1'b0;
      RSP_RDATA <= '0;
    end else begin
      HWE <= 1'b0;
      HRE <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_ERR <= 1'b0;
      case (state)
        IDLE: if (REQ_VALID && DEVRDY) begin
          wr_q <= REQ_WRITE;
          addr_q <= REQ_ADDR;
          wdata_q <= REQ_WDATA;
          idx <= 3'd0;
          HDOUT <= lbus_byte(REQ_WRITE, REQ_ADDR, REQ_WDATA, 3'd0);
          HWE <= 1'b1;
          state <= SEND;
        end
        SEND, GAP: if (adv && last) begin
          state <= wr_q ? DONE : RD_WAIT;
          RSP_VALID <= wr_q;
        end else if (adv) begin
          idx <= idx + 3'd1;
          HDOUT <= lbus_byte(wr_q, addr_q, wdata_q, idx + 3'd1);
          HWE <= 1'b1;
          state <= SEND;
        end else if (state == SEND) begin
          gap_cnt <= '0;
          state <= GAP;
        end else if (to_exp) begin
          RSP_VALID <= 1'b1;
          RSP_ERR <= 1'b1;
          state <= DONE;
        end else if (gap_cnt != 4'hf) gap_cnt <= gap_cnt + 4'd1;
        RD_WAIT: if (!RRDYn) begin
          HRE <= 1'b1;
          state <= RD_HI;
        end else if (to_exp) begin
          RSP_VALID <= 1'b1;
          RSP_ERR <= 1'b1;
          state <= DONE;
        end
        RD_HI: begin
          rd_hi <= HDIN;
          gap_cnt <= '0;
          state <= RD_GAP;
        end
        RD_GAP: if (gap_cnt == 4'd1) state <= RD_LO;
          else gap_cnt <= gap_cnt + 4'd1;
        RD_LO: if (HRE) begin
          RSP_RDATA <= {rd_hi, HDIN};
          RSP_VALID <= 1'b1;
          state <= DONE;
        end else if (!RRDYn) HRE <= 1'b1;
        else if (to_exp) begin
          RSP_VALID <= 1'b1;
          RSP_ERR <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lbus_master.sv
// tb_lbus_master: randomized bench pairing lbus_master with a behavioural target and a register scoreboard
module tb_lbus_master;
  import lbus_pkg::*;
  logic CLK = 0, RSTn = 0, REQ_VALID = 0, REQ_WRITE = 0, DEVRDY = 0;
  logic [15:0] REQ_ADDR = 0, REQ_WDATA = 0, RSP_RDATA;
  logic REQ_READY, RSP_VALID, RSP_ERR, HWE, HRE, WRDYn, RRDYn;
  logic [7:0] HDOUT, HDIN;
  logic force_rrdy = 0, force_wrdy = 0, rd_n;
  int vec = 0, miscmp = 0;
  assign RRDYn = rd_n | force_rrdy;
  assign WRDYn = force_wrdy;
  always #5 CLK = ~CLK;

  lbus_master #(.BYTE_GAP(1), .TIMEOUT(20), .TO_W(5)) dut (
    .CLK(CLK), .RSTn(RSTn), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .DEVRDY(DEVRDY), .RRDYn(RRDYn), .WRDYn(WRDYn), .HWE(HWE), .HRE(HRE),
    .HDOUT(HDOUT), .HDIN(HDIN)
  );

  // target side: decodes byte frames, serves reads hi byte first, ctrl is self-clearing
  logic [7:0] fb[$], obs[$], lo_byte;
  int hwe_cyc[$], hre_cnt = 0, overlap = 0, cyc = 0, rd_phase = 0;
  logic [15:0] tmem[logic [15:0]], tv;
  initial begin
    rd_n = 1;
    HDIN = 0;
    tmem[LBUS_ADDR_ID] = 16'h4522;
    forever begin
      @(posedge CLK); #1;
      cyc++;
      if (HWE && HRE) overlap++;
      if (!RSTn) begin
        fb.delete();
        rd_n = 1;
        rd_phase = 0;
      end else begin
        if (rd_phase == 2) begin HDIN = lo_byte; rd_phase = 3; end
        if (HRE) begin
          hre_cnt++;
          if (rd_phase == 1) rd_phase = 2;
          else begin rd_n = 1; rd_phase = 0; end
        end
        if (HWE) begin
          obs.push_back(HDOUT);
          hwe_cyc.push_back(cyc);
          fb.push_back(HDOUT);
          if (fb[0] == LBUS_CMD_WR && fb.size() == 5) begin
            if ({fb[1], fb[2]} != LBUS_ADDR_CTRL) tmem[{fb[1], fb[2]}] = {fb[3], fb[4]};
            fb.delete();
          end else if (fb[0] != LBUS_CMD_WR && fb.size() == 3) begin
            tv = tmem.exists({fb[1], fb[2]}) ? tmem[{fb[1], fb[2]}] : 16'h0;
            HDIN = tv[15:8];
            lo_byte = tv[7:0];
            rd_n = 0;
            rd_phase = 1;
            fb.delete();
          end
        end
      end
    end
  end

  logic [15:0] ref_mem[logic [15:0]], exp_last, rdv, d;
  logic erv;
  int lat, rw, base, hb, k, g;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction
  function automatic logic [47:0] exp_bytes(input logic wr, input logic [15:0] a, input logic [15:0] wd);
    return wr ? {8'd5, LBUS_CMD_WR, a, wd} : {8'd3, 16'h0, LBUS_CMD_RD, a};
  endfunction
  function automatic logic [47:0] got_bytes(input int b);
    logic [39:0] r = '0;
    for (int i = b; i < obs.size(); i++) r = {r[31:0], obs[i]};
    return {8'(obs.size() - b), r};
  endfunction

  task automatic start_req(input logic wr, input logic [15:0] a, input logic [15:0] wd, output int w);
    REQ_WRITE = wr; REQ_ADDR = a; REQ_WDATA = wd; REQ_VALID = 1; w = 0;
    while (!REQ_READY && w < 100) begin @(posedge CLK); #1; w++; end
    if (!REQ_READY) begin vec++; miscmp++; $display("FAIL req_ready_wait: REQ_READY stuck 0, want 1"); end
    @(posedge CLK); #1;
    REQ_VALID = 0;
    if (wr && a != LBUS_ADDR_CTRL) ref_mem[a] = wd;
  endtask
  task automatic wait_rsp(output int l);
    l = 0;
    while (!RSP_VALID && l < 200) begin @(posedge CLK); #1; l++; end
    if (!RSP_VALID) begin vec++; miscmp++; $display("FAIL rsp_wait: RSP_VALID stuck 0, want 1"); end
    rdv = RSP_RDATA;
    erv = RSP_ERR;
  endtask

  task automatic test_reset;
    DEVRDY = 0; RSTn = 0;
    repeat (3) @(posedge CLK);
    #1;
    vec++; if ({REQ_READY, HWE, HRE, RSP_VALID, RSP_ERR, HDOUT, RSP_RDATA} !== 29'h0) begin
      miscmp++; $display("FAIL reset_outputs: got %h want 0", {REQ_READY, HWE, HRE, RSP_VALID, RSP_ERR, HDOUT, RSP_RDATA}); end
    RSTn = 1;
    repeat (2) @(posedge CLK);
    #1;
    vec++; if (REQ_READY !== 1'b0) begin miscmp++; $display("FAIL ready_devrdy_low: got %b want 0", REQ_READY); end
    DEVRDY = 1; #1;
    vec++; if (REQ_READY !== 1'b1) begin miscmp++; $display("FAIL ready_idle: got %b want 1", REQ_READY); end
  endtask

  task automatic test_write_key;
    base = obs.size();
    start_req(1, LBUS_ADDR_KEY, 16'h2B7E, rw);
    wait_rsp(lat);
    vec++; if (got_bytes(base) !== exp_bytes(1, LBUS_ADDR_KEY, 16'h2B7E)) begin
      miscmp++; $display("FAIL wr_key_bytes: got %h want %h", got_bytes(base), exp_bytes(1, LBUS_ADDR_KEY, 16'h2B7E)); end
    vec++; if (lat != 10) begin miscmp++; $display("FAIL wr_latency: got %0d want 10", lat); end
    vec++; if (erv !== 1'b0) begin miscmp++; $display("FAIL wr_key_err: got %b want 0", erv); end
    vec++; if (tmem[LBUS_ADDR_KEY] !== 16'h2B7E) begin miscmp++; $display("FAIL target_key: got %h want 2b7e", tmem[LBUS_ADDR_KEY]); end
  endtask

  task automatic test_read_id;
    base = obs.size(); hb = hre_cnt;
    start_req(0, LBUS_ADDR_ID, 16'h0, rw);
    wait_rsp(lat);
    vec++; if (got_bytes(base) !== exp_bytes(0, LBUS_ADDR_ID, 16'h0)) begin
      miscmp++; $display("FAIL rd_id_bytes: got %h want %h", got_bytes(base), exp_bytes(0, LBUS_ADDR_ID, 16'h0)); end
    vec++; if (hre_cnt - hb != 2) begin miscmp++; $display("FAIL rd_id_hre: got %0d want 2", hre_cnt - hb); end
    vec++; if ({erv, rdv} !== {1'b0, 16'h4522}) begin miscmp++; $display("FAIL rd_id_data: got %b/%h want 0/4522", erv, rdv); end
    exp_last = 16'h4522;
  endtask

  task automatic test_timeout;
    base = obs.size(); hb = hre_cnt;
    force_rrdy = 1;
    start_req(0, LBUS_ADDR_DOUT, 16'h0, rw);
    wait_rsp(lat);
    force_rrdy = 0;
    vec++; if (got_bytes(base) !== exp_bytes(0, LBUS_ADDR_DOUT, 16'h0)) begin
      miscmp++; $display("FAIL to_bytes: got %h want %h", got_bytes(base), exp_bytes(0, LBUS_ADDR_DOUT, 16'h0)); end
    vec++; if (erv !== 1'b1) begin miscmp++; $display("FAIL to_err: got %b want 1", erv); end
    // three bytes plus one gap reach RD_WAIT after 6 cycles, then 20 wait cycles
    vec++; if (lat != 26) begin miscmp++; $display("FAIL to_latency: got %0d want 26", lat); end
    vec++; if (hre_cnt != hb) begin miscmp++; $display("FAIL to_hre: got %0d want 0", hre_cnt - hb); end
    vec++; if (rdv !== exp_last) begin miscmp++; $display("FAIL to_rdata_held: got %h want %h", rdv, exp_last); end
  endtask

  task automatic test_wrdy_stall;
    d = 16'($urandom);
    base = obs.size();
    start_req(1, LBUS_ADDR_DIN, d, rw);
    k = 0; g = 0;
    while (g < 50) begin
      if (HWE) k++;
      if (k == 3) break;
      @(posedge CLK); #1; g++;
    end
    vec++; if (k != 3) begin miscmp++; $display("FAIL stall_hwe_seen: got %0d want 3", k); end
    force_wrdy = 1;
    repeat (6) @(posedge CLK);
    #1;
    force_wrdy = 0;
    wait_rsp(lat);
    vec++; if (got_bytes(base) !== exp_bytes(1, LBUS_ADDR_DIN, d)) begin
      miscmp++; $display("FAIL stall_bytes: got %h want %h", got_bytes(base), exp_bytes(1, LBUS_ADDR_DIN, d)); end
    vec++; if (obs.size() < base + 4 || hwe_cyc[base+3] - hwe_cyc[base+2] != 7) begin
      miscmp++; $display("FAIL stall_delay: got %0d want 7", obs.size() < base + 4 ? -1 : hwe_cyc[base+3] - hwe_cyc[base+2]); end
    vec++; if (erv !== 1'b0) begin miscmp++; $display("FAIL stall_err: got %b want 0", erv); end
    start_req(0, LBUS_ADDR_DIN, 16'h0, rw);
    wait_rsp(lat);
    vec++; if ({erv, rdv} !== {1'b0, d}) begin miscmp++; $display("FAIL stall_readback: got %b/%h want 0/%h", erv, rdv, d); end
  endtask

  task automatic test_back_to_back;
    start_req(1, LBUS_ADDR_CTRL, 16'h0001, rw);
    wait_rsp(lat);
    start_req(0, LBUS_ADDR_CTRL, 16'h0, rw);
    vec++; if (rw != 1) begin miscmp++; $display("FAIL b2b_ready: got %0d cycles want 1", rw); end
    wait_rsp(lat);
    vec++; if ({erv, rdv} !== {1'b0, 16'h0000}) begin miscmp++; $display("FAIL b2b_ctrl_read: got %b/%h want 0/0000", erv, rdv); end
  endtask

  task automatic test_reset_mid;
    start_req(1, LBUS_ADDR_MODE, 16'($urandom), rw);
    ref_mem[LBUS_ADDR_MODE] = 16'h0;
    k = 0; g = 0;
    while (g < 50) begin
      if (HWE) k++;
      if (k == 3) break;
      @(posedge CLK); #1; g++;
    end
    RSTn = 0; #1;
    vec++; if ({HWE, HRE, RSP_VALID} !== 3'b000) begin miscmp++; $display("FAIL rst_mid_strobes: got %b want 000", {HWE, HRE, RSP_VALID}); end
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1;
    @(posedge CLK); #1;
    vec++; if ({REQ_READY, RSP_VALID} !== 2'b10) begin miscmp++; $display("FAIL rst_mid_idle: got %b want 10", {REQ_READY, RSP_VALID}); end
    d = 16'($urandom);
    base = obs.size();
    start_req(1, LBUS_ADDR_MODE, d, rw);
    wait_rsp(lat);
    vec++; if (got_bytes(base) !== exp_bytes(1, LBUS_ADDR_MODE, d) || lat != 10 || erv !== 1'b0) begin
      miscmp++; $display("FAIL rst_mid_write: got %h/%0d/%b want %h/10/0", got_bytes(base), lat, erv, exp_bytes(1, LBUS_ADDR_MODE, d)); end
    start_req(0, LBUS_ADDR_MODE, 16'h0, rw);
    wait_rsp(lat);
    vec++; if ({erv, rdv} !== {1'b0, d}) begin miscmp++; $display("FAIL rst_mid_read: got %b/%h want 0/%h", erv, rdv, d); end
  endtask

  task automatic test_random;
    logic [15:0] addrs[5] = '{LBUS_ADDR_MODE, LBUS_ADDR_KEY, LBUS_ADDR_DIN, LBUS_ADDR_DOUT, LBUS_ADDR_ID};
    logic wr;
    logic [15:0] a, e;
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 5) == 5 ? 16'($urandom) : addrs[$urandom_range(0, 4)];
      if (a == LBUS_ADDR_ID) wr = 0;
      d = 16'($urandom);
      e = ref_rd(a);
      base = obs.size();
      start_req(wr, a, d, rw);
      wait_rsp(lat);
      vec++; if (got_bytes(base) !== exp_bytes(wr, a, d)) begin
        miscmp++; $display("FAIL rand_bytes[%0d]: got %h want %h", i, got_bytes(base), exp_bytes(wr, a, d)); end
      vec++; if (erv !== 1'b0) begin miscmp++; $display("FAIL rand_err[%0d]: got %b want 0", i, erv); end
      vec++; if (wr ? lat != 10 : rdv !== e) begin
        miscmp++; $display("FAIL rand_result[%0d]: wr=%b lat=%0d rdata=%h want lat 10 / rdata %h", i, wr, lat, rdv, e); end
    end
  endtask

  initial begin
    ref_mem[LBUS_ADDR_ID] = 16'h4522;
    test_reset;
    test_write_key;
    test_read_id;
    test_timeout;
    test_wrdy_stall;
    test_back_to_back;
    test_reset_mid;
    test_random;
    vec++; if (overlap != 0) begin miscmp++; $display("FAIL strobe_overlap: got %0d cycles want 0", overlap); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
